// File: rtl/dmem_pkg.sv
// Shared constants, FSM encoding and lane helpers for the data-memory controller.
package dmem_pkg;

  localparam int BE_W = 4;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_t;

  // Byte enables for a store of the given size at the given lane.
  function automatic logic [BE_W-1:0] store_be(input logic [2:0] f3, input logic [1:0] lane);
    logic [BE_W-1:0] be;
    be = '0;
    case (f3)
      F3_B:    be = 4'b0001 << lane;
      F3_H:    be = lane[1] ? 4'b1100 : 4'b0011;
      F3_W:    be = 4'b1111;
      default: be = '0;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] lane,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_B:    r = {{24{b[7]}}, b};
      F3_BU:   r = {24'h0, b};
      F3_H:    r = {{16{h[15]}}, h};
      F3_HU:   r = {16'h0, h};
      default: r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_if.sv
// Core <-> data-memory request/response bundle. DMEM_PERF_EN adds the event counters.
interface dmem_if;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        resp_valid;
  logic        stall;
  logic        fault;
`ifdef DMEM_PERF_EN
  logic [31:0] load_cnt;
  logic [31:0] store_cnt;
  logic [31:0] fault_cnt;

  modport master (output mem_read, mem_write, funct3, addr, wdata,
                  input  rdata, resp_valid, stall, fault, load_cnt, store_cnt, fault_cnt);
  modport slave  (input  mem_read, mem_write, funct3, addr, wdata,
                  output rdata, resp_valid, stall, fault, load_cnt, store_cnt, fault_cnt);
`else
  modport master (output mem_read, mem_write, funct3, addr, wdata,
                  input  rdata, resp_valid, stall, fault);
  modport slave  (input  mem_read, mem_write, funct3, addr, wdata,
                  output rdata, resp_valid, stall, fault);
`endif
endinterface

// File: rtl/dmem_ram.sv
// Single-port word RAM with per-byte write enables and a registered read port.
module dmem_ram
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [BE_W-1:0] be,
  input  logic [AW-1:0]   widx,
  input  logic [31:0]     din,
  output logic [31:0]     dout
);

  logic [31:0] mem [DEPTH_WORDS];

  // NOTE: storage has no reset; clearing it would force flops instead of a RAM macro.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be[i]) mem[widx][8*i +: 8] <= din[8*i +: 8];
      end
    end
    dout <= mem[widx];
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory responder: sized/aligned loads and stores with one load stall cycle.
// Optional DMEM_PERF_EN adds load/store/fault event counters.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input logic   clk,
  input logic   rst,
  dmem_if.slave bus
);

  state_t          state, state_nx;
  logic            stall, fault, resp_valid, rd_issue, we;
  logic            legal_rd, legal_wr, aligned;
  logic [1:0]      lane;
  logic [2:0]      req_f3;
  logic [1:0]      req_lane;
  logic [31:0]     rdata_q, ram_dout, load_data, din;
  logic [BE_W-1:0] be;

  assign lane     = bus.addr[1:0];
  assign legal_rd = bus.funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  assign legal_wr = bus.funct3 inside {F3_B, F3_H, F3_W};

  always_comb begin
    case (bus.funct3[1:0])
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~bus.addr[0];
      2'b10:   aligned = (lane == 2'b00);
      default: aligned = 1'b0;
    endcase
  end

  // NOTE: every output gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_nx   = state;
    stall      = 1'b0;
    fault      = 1'b0;
    resp_valid = 1'b0;
    rd_issue   = 1'b0;
    we         = 1'b0;
    case (state)
      IDLE: begin
        if (bus.mem_read && bus.mem_write) begin
          fault = 1'b1;
        end else if (bus.mem_read) begin
          if (legal_rd && aligned) begin
            stall    = 1'b1;
            rd_issue = 1'b1;
            state_nx = RD_WAIT;
          end else begin
            fault = 1'b1;
          end
        end else if (bus.mem_write) begin
          if (legal_wr && aligned) we = 1'b1;
          else                     fault = 1'b1;
        end
      end
      RD_WAIT: begin
        resp_valid = 1'b1;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    // Reset cancels any access or response that would happen in this cycle.
    if (rst) begin
      stall      = 1'b0;
      fault      = 1'b0;
      resp_valid = 1'b0;
      rd_issue   = 1'b0;
      we         = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rdata_q  <= '0;
      req_f3   <= '0;
      req_lane <= '0;
    end else begin
      state <= state_nx;
      if (rd_issue) begin
        req_f3   <= bus.funct3;
        req_lane <= lane;
      end
      if (resp_valid) rdata_q <= load_data;
    end
  end

  always_comb begin
    case (bus.funct3)
      F3_B:    din = {4{bus.wdata[7:0]}};
      F3_H:    din = {2{bus.wdata[15:0]}};
      default: din = bus.wdata;
    endcase
  end

  assign be        = store_be(bus.funct3, lane);
  assign load_data = load_extend(req_f3, req_lane, ram_dout);

  dmem_ram #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_ram (
    .clk  (clk),
    .we   (we),
    .be   (be),
    .widx (bus.addr[AW+1:2]),
    .din  (din),
    .dout (ram_dout)
  );

  assign bus.rdata      = resp_valid ? load_data : rdata_q;
  assign bus.resp_valid = resp_valid;
  assign bus.stall      = stall;
  assign bus.fault      = fault;

`ifdef DMEM_PERF_EN
  logic [31:0] load_cnt, store_cnt, fault_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      load_cnt  <= '0;
      store_cnt <= '0;
      fault_cnt <= '0;
    end else begin
      if (resp_valid) load_cnt  <= load_cnt + 32'd1;
      if (we)         store_cnt <= store_cnt + 32'd1;
      if (fault)      fault_cnt <= fault_cnt + 32'd1;
    end
  end

  assign bus.load_cnt  = load_cnt;
  assign bus.store_cnt = store_cnt;
  assign bus.fault_cnt = fault_cnt;
`endif

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Data-memory responder for the RISC-V core; it serves the load/store requests raised by the decoder's MemRead/MemWrite controls.
- Owns a byte-addressed, word-organised synchronous RAM with a 1-cycle read latency.
- Performs byte, half and word access with sign/zero extension, and stalls the core for one cycle on loads.
- Flags misaligned and illegal-size accesses instead of performing them.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in RAM; must be a power of 2.
- AW, $clog2(DEPTH_WORDS), word-index width derived from DEPTH_WORDS.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_read  in  1  load request (decoder MemRead).
- mem_write  in  1  store request (decoder MemWrite).
- funct3  in  3  access size/signedness from the instruction.
- addr  in  32  byte address from the ALU result.
- wdata  in  32  store data (rs2); the low bytes are used for SB/SH.
- rdata  out  32  extended load result; valid only while resp_valid=1.
- resp_valid  out  1  load data valid this cycle.
- stall  out  1  freezes PC/pipeline when high (combinational).
- fault  out  1  one-cycle pulse on a misaligned/illegal access; no memory effect.

Behaviour:
- Reset:
  - state=IDLE; rdata=0, resp_valid=0, stall=0, fault=0.
  - RAM contents are not cleared.
  - A reset during RD_WAIT aborts the load with no response.
- Word index is addr[AW+1:2]; the address wraps modulo DEPTH_WORDS*4. The byte lane is addr[1:0].
- Legal funct3 values:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - All others are illegal.
- Alignment: half requires addr[0]=0; word requires addr[1:0]=00. Byte access is always aligned.
- FSM states:
  - IDLE: requests are evaluated here.
    - mem_read && legal && aligned: stall=1, RAM read issued, next state RD_WAIT.
    - mem_write && legal && aligned: byte-enable write at this clock edge, stall=0, single cycle, stay in IDLE.
      - SB writes lane addr[1:0] with wdata[7:0].
      - SH writes lanes {addr[1],0}/{addr[1],1} with wdata[15:0].
      - SW writes all four lanes.
    - illegal/misaligned request: fault=1 for that cycle, stall=0, no RAM access, stay in IDLE.
    - mem_read && mem_write both high: fault=1, no access.
  - RD_WAIT: RAM data is present. Drive rdata = the extended selected lane(s), resp_valid=1, stall=0. Request inputs are ignored, because they belong to the completing instruction. Next state IDLE.
  - Note: RD_WAIT is the response cycle; there is no separate third state.
- Load latency: 2 cycles from request to data, 1 stall cycle. Back-to-back loads cost 2 cycles each.
- A store immediately after a load is accepted in the IDLE cycle that follows RD_WAIT.
- Extension: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend. rdata holds its last value when resp_valid=0.

Optional Feature:
- DMEM_PERF_EN defined:
  - Adds outputs load_cnt[31:0], store_cnt[31:0] and fault_cnt[31:0].
  - Each counter increments once per completed load (in RD_WAIT), accepted store, or fault pulse.
  - Counters wrap at 2^32 and clear on rst.
- DMEM_PERF_EN undefined: these ports and counters do not exist; the rest of the behaviour is identical.

Decomposition:
- Package dmem_pkg:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - FSM state encoding (IDLE, RD_WAIT).
  - Byte-enable width constant (4).
- Sub-module dmem_ram:
  - Single-port synchronous RAM with 4-bit byte enable and registered read data.
  - Ports: clk, we, be[3:0], widx[AW-1:0], din[31:0], dout[31:0].
- Lane select, extension and alignment checking stay in dmem_ctrl.

Test Plan:
- SW addr=0x10 wdata=0xDEADBEEF, then LW 0x10 -> stall=1 for one cycle, next cycle resp_valid=1, rdata=0xDEADBEEF.
- SB addr=0x13 wdata=0x80, then LB 0x13 -> rdata=0xFFFFFF80; LBU 0x13 -> rdata=0x00000080; LW 0x10 -> 0x80ADBEEF.
- SH addr=0x22 wdata=0x8001, then LH 0x22 -> 0xFFFF8001; LHU -> 0x00008001.
- LW addr=0x12 or LH addr=0x21 or funct3=011 -> fault=1 for one cycle, stall=0, RAM unchanged (verified by a later LW).
- Addr=DEPTH_WORDS*4+0x10 with DEPTH_WORDS=1024: a load aliases word 4; both mem_read and mem_write high -> fault=1, no write.
- rst asserted in RD_WAIT -> next cycle state IDLE, resp_valid=0, stall=0, rdata=0; with DMEM_PERF_EN, the counters read 0.
